// File: rtl/gcd_arbiter_seq.sv
// gcd_arbiter_seq
//   One iterative subtract-based GCD engine shared between two requesters.
//   Round-robin arbitration between requesters; each uses a req/ack handshake.
//   Any zero operand yields a result of 0.
//
// Ports
//   Clock       system clock, all state updates on the rising edge
//   Reset       synchronous, active-high reset
//   Req0/Req1   job requests, held high until the matching Ack
//   X0/Y0       operands of requester 0 (sampled on the grant edge)
//   X1/Y1       operands of requester 1 (sampled on the grant edge)
//   Ack0/Ack1   one-cycle completion pulses
//   Result      GCD of the last completed job, held until the next completion
//   Grant       index of the requester owning the engine (meaningful while Busy)
//   Busy        high while a job is computing or completing
module gcd_arbiter_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [WIDTH-1:0] X0,
    input  logic [WIDTH-1:0] Y0,
    output logic             Ack0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] Y1,
    output logic             Ack1,
    output logic [WIDTH-1:0] Result,
    output logic             Grant,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] result_next;
    logic             grant_next;
    logic             ptr;
    logic             ptr_next;
    logic             winner;
    logic             ack0_next;
    logic             ack1_next;
    logic             busy_next;

    // State, datapath and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            ptr    <= 1'b0;
            Result <= '0;
            Grant  <= 1'b0;
            Ack0   <= 1'b0;
            Ack1   <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_next;
            a      <= a_next;
            b      <= b_next;
            ptr    <= ptr_next;
            Result <= result_next;
            Grant  <= grant_next;
            Ack0   <= ack0_next;
            Ack1   <= ack1_next;
            Busy   <= busy_next;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_next  = state;
        a_next      = a;
        b_next      = b;
        result_next = Result;
        grant_next  = Grant;
        ptr_next    = ptr;
        winner      = 1'b0;
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    // Contention is resolved by the pointer; a lone request wins outright.
                    winner     = (Req0 && Req1) ? ptr : Req1;
                    grant_next = winner;
                    a_next     = winner ? X1 : X0;
                    b_next     = winner ? Y1 : Y0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (a == '0 || b == '0) begin
                    result_next = '0;
                    state_next  = DONE;
                end else if (a == b) begin
                    result_next = a;
                    state_next  = DONE;
                end else if (a > b) begin
                    a_next = a - b;
                end else begin
                    b_next = b - a;
                end
            end
            DONE: begin
                // Pointer moves only on completion, so held requests alternate.
                ptr_next   = ~Grant;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state so that the outputs come straight from flops
    always_comb begin
        busy_next = (state_next != IDLE);
        ack0_next = (state_next == DONE) && !grant_next;
        ack1_next = (state_next == DONE) &&  grant_next;
    end

endmodule
